// File: rtl/rv32_alu_arbiter.sv
// Two-requester arbiter in front of a single RV32 integer ALU, with a one-entry registered response slot.
// Define RV32_ALU_ARB_FIXED_PRIO_EN to make requester 0 always win contention instead of round-robin.
package rv32_alu_arbiter_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } int_alu_op_t;

  localparam int unsigned OP_W = $bits(int_alu_op_t);
endpackage

// Purely combinational RV32 integer ALU.
module rv32_int_alu
  import rv32_alu_arbiter_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  int_alu_op_t opsel,
  output logic [31:0] result_c
);
  logic [4:0] shamt;
  assign shamt = op2[4:0];

  always_comb begin
    result_c = '0;
    case (opsel)
      ALU_ADD:  result_c = op1 + op2;
      ALU_SUB:  result_c = op1 - op2;
      ALU_SLL:  result_c = op1 << shamt;
      ALU_SLT:  result_c = {31'b0, $signed(op1) < $signed(op2)};
      ALU_SLTU: result_c = {31'b0, op1 < op2};
      ALU_XOR:  result_c = op1 ^ op2;
      ALU_SRL:  result_c = op1 >> shamt;
      ALU_SRA:  result_c = 32'($signed(op1) >>> shamt);
      ALU_OR:   result_c = op1 | op2;
      ALU_AND:  result_c = op1 & op2;
      default:  result_c = '0;
    endcase
  end
endmodule

module rv32_alu_arbiter
  import rv32_alu_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][31:0]      req_op1,
  input  logic [1:0][31:0]      req_op2,
  input  logic [1:0][OP_W-1:0]  req_opsel,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_result,
  output logic                  rsp_id,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic [31:0]           op_count
);
  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_c;
  logic        gnt_idx_c;
  logic        can_accept_c;
  logic        accept_c;
  logic [31:0] alu_result_c;

`ifdef RV32_ALU_ARB_FIXED_PRIO_EN
  // Requester 0 wins every contention; no fairness state.
  always_comb begin
    grant_c = req_valid;
    if (req_valid == 2'b11) grant_c = 2'b01;
  end
`else
  logic last_q;

  // Under contention, the requester not granted most recently wins.
  always_comb begin
    grant_c = req_valid;
    if (req_valid == 2'b11) grant_c = last_q ? 2'b01 : 2'b10;
  end

  // Pointer only moves on an accepted grant, never on a stalled one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       last_q <= 1'b1;
    else if (accept_c) last_q <= gnt_idx_c;
  end
`endif

  assign gnt_idx_c    = grant_c[1];
  assign rsp_valid    = (state_q == S_FULL);
  assign can_accept_c = (state_q == S_EMPTY) || (rsp_valid && rsp_ready);
  assign req_ready    = grant_c & {2{can_accept_c && resetn}};
  assign accept_c     = |req_ready;

  rv32_int_alu u_alu (
    .op1      (req_op1[gnt_idx_c]),
    .op2      (req_op2[gnt_idx_c]),
    .opsel    (int_alu_op_t'(req_opsel[gnt_idx_c])),
    .result_c (alu_result_c)
  );

  // Response slot: an accept always refills; a drain without accept empties.
  always_comb begin
    state_d = state_q;
    if (accept_c)                           state_d = S_FULL;
    else if (state_q == S_FULL && rsp_ready) state_d = S_EMPTY;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_EMPTY;
      rsp_result <= '0;
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
      op_count   <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        rsp_result <= alu_result_c;
        rsp_id     <= gnt_idx_c;
        rsp_tag    <= req_tag[gnt_idx_c];
        op_count   <= op_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_rv32_alu_arbiter.sv
// Directed scoreboard bench for rv32_alu_arbiter; honours RV32_ALU_ARB_FIXED_PRIO_EN for grant expectations.
module tb_rv32_alu_arbiter;
  import rv32_alu_arbiter_pkg::*;

  localparam int unsigned TAG_W = 4;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][31:0]      req_op1;
  logic [1:0][31:0]      req_op2;
  logic [1:0][OP_W-1:0]  req_opsel;
  logic [1:0][TAG_W-1:0] req_tag;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_result;
  logic                  rsp_id;
  logic [TAG_W-1:0]      rsp_tag;
  logic [31:0]           op_count;

  always #5 clk = ~clk;

  rv32_alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_opsel  (req_opsel),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .rsp_tag    (rsp_tag),
    .op_count   (op_count)
  );

  typedef struct packed {
    logic [31:0]      res;
    logic             id;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;
  logic        m_last;
  logic        m_full;
  logic [31:0] m_cnt;
  logic [1:0]  obs_ready;

`ifdef RV32_ALU_ARB_FIXED_PRIO_EN
  localparam logic [31:0] CONTEND_LAST_RES = 32'h0FF0_00FF;
  localparam logic        CONTEND_LAST_ID  = 1'b0;
`else
  localparam logic [31:0] CONTEND_LAST_RES = 32'hF800_0000;
  localparam logic        CONTEND_LAST_ID  = 1'b1;
`endif

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input int_alu_op_t op);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input int_alu_op_t op, input logic [TAG_W-1:0] t);
    req_op1[i]   = a;
    req_op2[i]   = b;
    req_opsel[i] = op;
    req_tag[i]   = t;
  endtask

  // One clock: sample and score at negedge, update the model, return 1 time unit after the posedge.
  task automatic cyc();
    logic [1:0] eg;
    logic [1:0] er;
    exp_t       e;
    @(negedge clk);
    if (req_valid == 2'b11) begin
`ifdef RV32_ALU_ARB_FIXED_PRIO_EN
      eg = 2'b01;
`else
      eg = m_last ? 2'b01 : 2'b10;
`endif
    end else begin
      eg = req_valid;
    end
    er = (m_full && !rsp_ready) ? 2'b00 : eg;
    obs_ready = req_ready;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
    chk("op_count", op_count, m_cnt);
    if (m_full) begin
      n_total++;
      assert (sb.size() != 0) n_pass++;
      else begin
        n_fail++;
        $error("FAIL sb_nonempty observed=0 expected=1");
      end
      if (sb.size() != 0) begin
        chk("sb_result", rsp_result, sb[0].res);
        chk("sb_id", 32'(rsp_id), 32'(sb[0].id));
        chk("sb_tag", 32'(rsp_tag), 32'(sb[0].tag));
        if (rsp_ready) void'(sb.pop_front());
      end
    end
    if (er != 2'b00) begin
      e.id  = er[1];
      e.tag = req_tag[er[1]];
      e.res = ref_alu(req_op1[er[1]], req_op2[er[1]], int_alu_op_t'(req_opsel[er[1]]));
      sb.push_back(e);
      m_last = er[1];
      m_cnt  = m_cnt + 32'd1;
    end
    m_full = (er != 2'b00) || (m_full && !rsp_ready);
    @(posedge clk);
    #1;
  endtask

  // Asserts reset away from a clock edge, checks it clears immediately and blocks accepts.
  task automatic do_reset();
    #2;
    resetn    = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_op_count", op_count, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    sb.delete();
    m_last = 1'b1;
    m_full = 1'b0;
    m_cnt  = '0;
    @(posedge clk);
    #1;
    chk("rst_hold_req_ready", 32'(req_ready), 32'd0);
    chk("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn    = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    req_op1   = '0;
    req_op2   = '0;
    req_opsel = '0;
    req_tag   = '0;
    do_reset();

    // Single request from requester 0
    rsp_ready = 1'b1;
    set_req(0, 32'd5, 32'd7, ALU_ADD, 4'd3);
    req_valid = 2'b01;
    cyc();
    chk("single_ready", 32'(obs_ready), 32'h1);
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_result", rsp_result, 32'd12);
    chk("single_id", 32'(rsp_id), 32'd0);
    chk("single_tag", 32'(rsp_tag), 32'd3);
    chk("single_count", op_count, 32'd1);
    req_valid = 2'b00;
    cyc();

    // Contention straight after reset
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 32'h0F0F_0000, 32'h00FF_00FF, ALU_XOR, 4'h1);
    set_req(1, 32'h8000_0000, 32'd4, ALU_SRA, 4'h2);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      cyc();
`ifdef RV32_ALU_ARB_FIXED_PRIO_EN
      chk($sformatf("contend_gnt%0d", k), 32'(obs_ready), 32'h1);
`else
      chk($sformatf("contend_gnt%0d", k), 32'(obs_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
`endif
    end
    chk("contend_result", rsp_result, CONTEND_LAST_RES);
    chk("contend_id", 32'(rsp_id), 32'(CONTEND_LAST_ID));

    // Backpressure with both valid, then release
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("bp_ready%0d", k), 32'(obs_ready), 32'h0);
      chk($sformatf("bp_result%0d", k), rsp_result, CONTEND_LAST_RES);
      chk($sformatf("bp_count%0d", k), op_count, 32'd4);
    end
    rsp_ready = 1'b1;
    cyc();
    chk("bp_release_gnt", 32'(obs_ready), 32'h1);
    chk("bp_release_result", rsp_result, 32'h0FF0_00FF);

    // Drain and accept in the same cycle
    set_req(1, 32'd1, 32'd2, ALU_SLTU, 4'h5);
    req_valid = 2'b10;
    cyc();
    chk("drain_acc_ready", 32'(obs_ready), 32'h2);
    chk("drain_acc_valid", 32'(rsp_valid), 32'd1);
    chk("drain_acc_result", rsp_result, 32'd1);
    chk("drain_acc_id", 32'(rsp_id), 32'd1);
    req_valid = 2'b00;
    cyc();

    // Reset while holding a response
    rsp_ready = 1'b0;
    set_req(0, 32'h1230, 32'h4, ALU_ADD, 4'h6);
    req_valid = 2'b01;
    cyc();
    chk("mid_full_result", rsp_result, 32'h1234);
    req_valid = 2'b00;
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    cyc();
    chk("post_rst_gnt", 32'(obs_ready), 32'h1);
    req_valid = 2'b00;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rv32_alu_arbiter.md
RV32_ALU_ARBITER -- requirements
Module: rv32_alu_arbiter

Interface
REQ-001 Parameter: TAG_W, default 4, width of the requester tag carried from request to response.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  2  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester request accepted this cycle.
REQ-007 req_op1  input  2x32  per-requester ALU operand 1.
REQ-008 req_op2  input  2x32  per-requester ALU operand 2.
REQ-009 req_opsel  input  2x int_alu_op_t  per-requester ALU operation.
REQ-010 req_tag  input  2xTAG_W  per-requester opaque tag.
REQ-011 rsp_valid  output  1  response register holds a result.
REQ-012 rsp_ready  input  1  consumer accepts the response this cycle.
REQ-013 rsp_result  output  32  registered ALU result.
REQ-014 rsp_id  output  1  index of the requester that issued the result.
REQ-015 rsp_tag  output  TAG_W  tag of the issuing request.
REQ-016 op_count  output  32  number of accepted requests since reset.

Function
REQ-017 The block SHALL instantiate exactly one rv32_int_alu, with its operands and opsel muxed from the granted requester.
REQ-018 The response register SHALL form a two-state FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-019 can_accept SHALL equal (state==EMPTY) or (rsp_valid and rsp_ready).
REQ-020 Grant: with one valid requester, it SHALL be granted; with both valid, the requester not granted most recently SHALL be granted.
REQ-021 req_ready[i] SHALL be high only when grant[i] and can_accept are both high; at most one bit SHALL be high per cycle.
REQ-022 req_ready SHALL depend combinationally on req_valid and rsp_ready; rsp_valid SHALL NOT depend on req_valid or rsp_ready in the same cycle.
REQ-023 On accept, the ALU result, rsp_id and rsp_tag SHALL be registered at the next edge: latency from accept to rsp_valid SHALL be exactly 1 cycle.
REQ-024 Transitions: EMPTY+accept -> FULL; FULL+drain with no accept -> EMPTY; FULL+drain+accept -> FULL with new contents; FULL without drain -> FULL with contents held stable.
REQ-025 The round-robin pointer SHALL update only on an accepted grant; a grant that is stalled by FULL without drain SHALL NOT move it.
REQ-026 op_count SHALL increment by 1 per accept and wrap from 0xFFFFFFFF to 0.
REQ-027 With no valid request, req_ready SHALL be 0 and the ALU inputs SHALL be don't-care.

Reset
REQ-028 Asserting resetn low SHALL immediately set rsp_valid=0, rsp_result=0, rsp_id=0, rsp_tag=0, op_count=0, state EMPTY, last-grant pointer=1 (so requester 0 wins first contention).
REQ-029 A response held at reset assertion SHALL be discarded; no request SHALL be accepted while resetn is low.

Configuration
REQ-030 With RV32_ALU_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win contention and the pointer SHALL be removed.
REQ-031 Without RV32_ALU_ARB_FIXED_PRIO_EN, the round-robin grant from REQ-020 and REQ-025 SHALL apply.

Verification
REQ-032 Single request: req_valid=01, op1=5, op2=7, ADD, tag=3, rsp_ready=1 -> req_ready=01; next cycle rsp_valid=1, result=12, id=0, tag=3; op_count=1.
REQ-033 Contention after reset: both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; requester 1 SRA 0x80000000 by 4 -> 0xF8000000.
REQ-034 Backpressure: response FULL, rsp_ready=0 for 3 cycles with both valid -> req_ready=00, rsp fields stable, pointer unchanged; on rsp_ready=1 the pending winner is accepted the same cycle.
REQ-035 Simultaneous drain+accept: FULL, rsp_ready=1, req_valid=10, SLTU 1<2 -> next cycle rsp_valid=1, result=1, id=1, no bubble.
REQ-036 Reset mid-operation: FULL with result 0x1234, resetn low -> rsp_valid=0 and op_count=0 before the next edge; the first contention after release grants requester 0.
REQ-037 With RV32_ALU_ARB_FIXED_PRIO_EN, both requesters valid for 4 cycles -> requester 0 granted every cycle.
